// File: rtl/sal_cfg_mc_if.sv
// APB bus bundle between the configuration master and sal_cfg_mc.
interface APB_IF #(
    parameter int ADDR_W = 12
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport MST (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport SLV (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/sal_cfg_mc.sv
// Multi-channel TLP header configuration block: APB register file, per-channel
// start/busy/done handshake and shadowed header outputs latched at start.
module sal_cfg_mc #(
    parameter int          NUM_CH    = 4,
    parameter int          LEN_W     = 10,
    parameter int          ADDR_W    = 12,
    parameter int          CH_BASE   = 'h100,
    parameter int          CH_STRIDE = 'h10,
    parameter logic [31:0] VERSION   = 32'h0002_0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    APB_IF.SLV                           apb_if,
    output logic [NUM_CH-1:0][2:0]       hdr_fmt_o,
    output logic [NUM_CH-1:0][4:0]       hdr_type_o,
    output logic [NUM_CH-1:0][2:0]       hdr_tc_o,
    output logic [NUM_CH-1:0][LEN_W-1:0] hdr_length_o,
    output logic [NUM_CH-1:0][15:0]      hdr_reqid_o,
    output logic [NUM_CH-1:0][15:0]      hdr_cplid_o,
    output logic [NUM_CH-1:0]            ch_start_o,
    input  logic [NUM_CH-1:0]            ch_done_i,
    output logic                         irq_o
);

    localparam int                HDR0_W   = 11 + LEN_W;
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(CH_BASE);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(CH_STRIDE);

    logic [NUM_CH-1:0][HDR0_W-1:0] hdr0_q, hdr0_d, sh_hdr0_q, sh_hdr0_d;
    logic [NUM_CH-1:0][31:0]       hdr1_q, hdr1_d, sh_hdr1_q, sh_hdr1_d;
    logic [NUM_CH-1:0]             irq_en_q, irq_en_d;
    logic [NUM_CH-1:0]             busy_q, busy_d;
    logic [NUM_CH-1:0]             done_q, done_d;
    logic [NUM_CH-1:0]             err_q, err_d;
    logic [NUM_CH-1:0]             start_q, start_d;
    logic                          irq_q, irq_d;
    logic [31:0]                   prdata_q, prdata_d;
    logic                          pslverr_q, pslverr_d;
    logic                          sbb_q, sbb_d;

    logic [ADDR_W-1:0] addr_w, off, ch_num, reg_off;
    logic [1:0]        reg_sel;
    logic              is_ver, is_irq, is_ch;
    logic [NUM_CH-1:0] ch_sel;
    logic              setup, access, wr_ok, sbb_now, err_now;
    logic [31:0]       rdata;
    logic              unused_bits;

    assign unused_bits = ^apb_if.paddr[1:0];

    // Address decode; the low two address bits never take part.
    always_comb begin
        addr_w  = {apb_if.paddr[ADDR_W-1:2], 2'b00};
        off     = addr_w - BASE_A;
        ch_num  = off / STRIDE_A;
        reg_off = off % STRIDE_A;
        reg_sel = reg_off[3:2];
        is_ver  = (addr_w == '0);
        is_irq  = (addr_w == ADDR_W'(4));
        is_ch   = (addr_w >= BASE_A) && (ch_num < ADDR_W'(NUM_CH))
                  && (reg_off < ADDR_W'(16));
        for (int c = 0; c < NUM_CH; c++) begin
            ch_sel[c] = is_ch && (ch_num == ADDR_W'(c));
        end
    end

    always_comb begin
        rdata = '0;
        if (is_ver) rdata = VERSION;
        if (is_irq) rdata = 32'(done_q & irq_en_q);
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel[c]) begin
                case (reg_sel)
                    2'd0:    rdata = 32'(hdr0_q[c]);
                    2'd1:    rdata = hdr1_q[c];
                    2'd2:    rdata = {30'b0, irq_en_q[c], 1'b0};
                    default: rdata = {29'b0, err_q[c], done_q[c], busy_q[c]};
                endcase
            end
        end
    end

    always_comb begin
        setup   = apb_if.psel && !apb_if.penable;
        access  = apb_if.psel && apb_if.penable;
        sbb_now = apb_if.pwrite && is_ch && (reg_sel == 2'd2) && apb_if.pwdata[0]
                  && |(ch_sel & busy_q);
        err_now = !(is_ver || is_irq || is_ch)
                  || (apb_if.pwrite && (is_ver || is_irq))
                  || sbb_now;
        wr_ok   = access && apb_if.pwrite && !pslverr_q;

        // Response is captured in the setup cycle and dropped after the access cycle.
        prdata_d  = '0;
        pslverr_d = 1'b0;
        sbb_d     = 1'b0;
        if (setup) begin
            prdata_d  = apb_if.pwrite ? '0 : rdata;
            pslverr_d = err_now;
            sbb_d     = sbb_now;
        end

        hdr0_d    = hdr0_q;
        hdr1_d    = hdr1_q;
        sh_hdr0_d = sh_hdr0_q;
        sh_hdr1_d = sh_hdr1_q;
        irq_en_d  = irq_en_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        start_d   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_ok && ch_sel[c]) begin
                case (reg_sel)
                    2'd0: hdr0_d[c] = apb_if.pwdata[HDR0_W-1:0];
                    2'd1: hdr1_d[c] = apb_if.pwdata;
                    2'd2: begin
                        irq_en_d[c] = apb_if.pwdata[1];
                        if (apb_if.pwdata[0]) begin
                            start_d[c]   = 1'b1;
                            busy_d[c]    = 1'b1;
                            done_d[c]    = 1'b0;
                            sh_hdr0_d[c] = hdr0_q[c];
                            sh_hdr1_d[c] = hdr1_q[c];
                        end
                    end
                    default: begin
                        if (apb_if.pwdata[1]) done_d[c] = 1'b0;
                        if (apb_if.pwdata[2]) err_d[c]  = 1'b0;
                    end
                endcase
            end
            if (access && apb_if.pwrite && sbb_q && ch_sel[c]) err_d[c] = 1'b1;
            // Completion is evaluated last so it overrides a same-cycle W1C.
            if (busy_q[c] && ch_done_i[c]) begin
                busy_d[c] = 1'b0;
                done_d[c] = 1'b1;
            end
        end
        irq_d = |(done_q & irq_en_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr0_q    <= '0;
            hdr1_q    <= '0;
            sh_hdr0_q <= '0;
            sh_hdr1_q <= '0;
            irq_en_q  <= '0;
            busy_q    <= '0;
            done_q    <= '0;
            err_q     <= '0;
            start_q   <= '0;
            irq_q     <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            sbb_q     <= 1'b0;
        end else begin
            hdr0_q    <= hdr0_d;
            hdr1_q    <= hdr1_d;
            sh_hdr0_q <= sh_hdr0_d;
            sh_hdr1_q <= sh_hdr1_d;
            irq_en_q  <= irq_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            start_q   <= start_d;
            irq_q     <= irq_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            sbb_q     <= sbb_d;
        end
    end

    assign apb_if.pready  = 1'b1;
    assign apb_if.prdata  = prdata_q;
    assign apb_if.pslverr = pslverr_q;
    assign ch_start_o     = start_q;
    assign irq_o          = irq_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_hdr
        assign hdr_fmt_o[c]    = sh_hdr0_q[c][2:0];
        assign hdr_type_o[c]   = sh_hdr0_q[c][7:3];
        assign hdr_tc_o[c]     = sh_hdr0_q[c][10:8];
        assign hdr_length_o[c] = sh_hdr0_q[c][HDR0_W-1:11];
        assign hdr_reqid_o[c]  = sh_hdr1_q[c][15:0];
        assign hdr_cplid_o[c]  = sh_hdr1_q[c][31:16];
    end

endmodule

// File: tb/tb_sal_cfg_mc.sv
// Scoreboard bench for sal_cfg_mc: APB stimulus pushes expectations derived from
// a register-level model; a negedge monitor pops and compares.
module tb_sal_cfg_mc;
    localparam int NCH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    APB_IF #(.ADDR_W(12)) apb();

    logic [NCH-1:0][2:0]  hdr_fmt_o;
    logic [NCH-1:0][4:0]  hdr_type_o;
    logic [NCH-1:0][2:0]  hdr_tc_o;
    logic [NCH-1:0][9:0]  hdr_length_o;
    logic [NCH-1:0][15:0] hdr_reqid_o;
    logic [NCH-1:0][15:0] hdr_cplid_o;
    logic [NCH-1:0]       ch_start_o;
    logic [NCH-1:0]       ch_done_i = '0;
    logic                 irq_o;

    sal_cfg_mc dut (
        .clk(clk), .rst_n(rst_n), .apb_if(apb),
        .hdr_fmt_o(hdr_fmt_o), .hdr_type_o(hdr_type_o), .hdr_tc_o(hdr_tc_o),
        .hdr_length_o(hdr_length_o), .hdr_reqid_o(hdr_reqid_o), .hdr_cplid_o(hdr_cplid_o),
        .ch_start_o(ch_start_o), .ch_done_i(ch_done_i), .irq_o(irq_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [20:0] m_hdr0 [NCH];
    logic [31:0] m_hdr1 [NCH];
    bit          m_en   [NCH];
    bit          m_busy [NCH];
    bit          m_done [NCH];
    bit          m_err  [NCH];

    typedef struct { logic [31:0] rd; logic err; } exp_t;
    typedef struct { int ch; logic [20:0] h0; logic [31:0] h1; } st_t;
    exp_t exp_q[$];
    st_t  st_q[$];
    exp_t mon_e;
    st_t  mon_s;
    logic irq_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            m_hdr0[c] = '0; m_hdr1[c] = '0;
            m_en[c] = 0; m_busy[c] = 0; m_done[c] = 0; m_err[c] = 0;
        end
    endtask

    // 1 version, 2 irq status, 3 channel register, 0 unmapped
    function automatic int decode(input logic [11:0] a, output int ch, output int r);
        int aw;
        aw = int'(a) & 'hFFC;
        ch = 0; r = 0;
        if (aw == 0) return 1;
        if (aw == 4) return 2;
        if (aw >= 'h100 && (aw - 'h100) / 16 < NCH) begin
            ch = (aw - 'h100) / 16;
            r  = ((aw - 'h100) % 16) / 4;
            return 3;
        end
        return 0;
    endfunction

    function automatic logic [31:0] model_rd(input int kind, input int ch, input int r);
        logic [31:0] v;
        v = '0;
        if (kind == 1) v = 32'h0002_0000;
        if (kind == 2) for (int c = 0; c < NCH; c++) v[c] = m_done[c] & m_en[c];
        if (kind == 3) begin
            case (r)
                0: v = {11'b0, m_hdr0[ch]};
                1: v = m_hdr1[ch];
                2: v = {30'b0, m_en[ch], 1'b0};
                default: v = {29'b0, m_err[ch], m_done[ch], m_busy[ch]};
            endcase
        end
        return v;
    endfunction

    function automatic logic model_irq();
        logic v;
        v = 1'b0;
        for (int c = 0; c < NCH; c++) v = v | (m_done[c] & m_en[c]);
        return v;
    endfunction

    task automatic apb_xfer(input logic wr, input logic [11:0] a, input logic [31:0] d,
                            input logic [NCH-1:0] dn = '0);
        int kind, ch, r;
        logic err, sbb;
        exp_t e;
        bit old_busy [NCH];
        kind = decode(a, ch, r);
        sbb  = wr && kind == 3 && r == 2 && d[0] && m_busy[ch];
        err  = (kind == 0) || (wr && (kind == 1 || kind == 2)) || sbb;
        e.err = err;
        e.rd  = (wr || err) ? 32'h0 : model_rd(kind, ch, r);
        exp_q.push_back(e);
        if (wr && !err && kind == 3 && r == 2 && d[0])
            st_q.push_back('{ch, m_hdr0[ch], m_hdr1[ch]});
        @(posedge clk); #1;
        apb.psel = 1; apb.penable = 0; apb.pwrite = wr; apb.paddr = a; apb.pwdata = d;
        @(posedge clk); #1;
        apb.penable = 1; ch_done_i = dn;
        @(posedge clk); #1;
        apb.psel = 0; apb.penable = 0; ch_done_i = '0;
        for (int c = 0; c < NCH; c++) old_busy[c] = m_busy[c];
        if (wr && sbb) m_err[ch] = 1;
        else if (wr && !err && kind == 3) begin
            case (r)
                0: m_hdr0[ch] = d[20:0];
                1: m_hdr1[ch] = d;
                2: begin
                    m_en[ch] = d[1];
                    if (d[0]) begin m_busy[ch] = 1; m_done[ch] = 0; end
                end
                default: begin
                    if (d[1]) m_done[ch] = 0;
                    if (d[2]) m_err[ch] = 0;
                end
            endcase
        end
        for (int c = 0; c < NCH; c++)
            if (dn[c] && old_busy[c]) begin m_busy[c] = 0; m_done[c] = 1; end
    endtask

    task automatic done_pulse(input logic [NCH-1:0] v);
        @(posedge clk); #1 ch_done_i = v;
        @(posedge clk); #1 ch_done_i = '0;
        for (int c = 0; c < NCH; c++)
            if (v[c] && m_busy[c]) begin m_busy[c] = 0; m_done[c] = 1; end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) irq_prev = 1'b0;
        else begin
            if (apb.psel && apb.penable) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL apb_unexpected: got access to %0h, expected none", apb.paddr);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("apb_pslverr", 64'(apb.pslverr), 64'(mon_e.err));
                    check("apb_prdata", 64'(apb.prdata), 64'(mon_e.rd));
                end
            end
            for (int c = 0; c < NCH; c++) begin
                if (ch_start_o[c]) begin
                    if (st_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL start_unexpected: got pulse on ch %0d, expected none", c);
                    end else begin
                        mon_s = st_q.pop_front();
                        check("start_ch", 64'(c), 64'(mon_s.ch));
                        check("hdr_fmt", 64'(hdr_fmt_o[c]), 64'(mon_s.h0[2:0]));
                        check("hdr_type", 64'(hdr_type_o[c]), 64'(mon_s.h0[7:3]));
                        check("hdr_tc", 64'(hdr_tc_o[c]), 64'(mon_s.h0[10:8]));
                        check("hdr_length", 64'(hdr_length_o[c]), 64'(mon_s.h0[20:11]));
                        check("hdr_reqid", 64'(hdr_reqid_o[c]), 64'(mon_s.h1[15:0]));
                        check("hdr_cplid", 64'(hdr_cplid_o[c]), 64'(mon_s.h1[31:16]));
                    end
                end
            end
            check("irq_o", 64'(irq_o), 64'(irq_prev));
            irq_prev = model_irq();
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1);
    end

    initial begin
        logic [11:0] a;
        apb.psel = 0; apb.penable = 0; apb.pwrite = 0; apb.paddr = '0; apb.pwdata = '0;
        model_clear();
        #23 rst_n = 1'b1;
        idle(2);
        apb_xfer(0, 12'h000, 0);

        // channel 0 program and start
        apb_xfer(1, 12'h100, 32'h0000_8102);
        apb_xfer(1, 12'h104, 32'hBEEF_0100);
        apb_xfer(0, 12'h100, 0);
        apb_xfer(0, 12'h104, 0);
        check("pre_start_len", 64'(hdr_length_o[0]), 64'd0);
        check("pre_start_cplid", 64'(hdr_cplid_o[0]), 64'd0);
        apb_xfer(1, 12'h108, 32'h1);
        idle(1);
        check("started_len", 64'(hdr_length_o[0]), 64'd16);
        apb_xfer(0, 12'h10C, 0);

        // start while busy, reprogram while busy
        apb_xfer(1, 12'h108, 32'h1);
        apb_xfer(0, 12'h10C, 0);
        apb_xfer(1, 12'h100, 32'h0001_0102);
        idle(2);
        check("hold_len", 64'(hdr_length_o[0]), 64'd16);

        // completion and interrupt on channel 2
        apb_xfer(1, 12'h128, 32'h2);
        apb_xfer(1, 12'h128, 32'h3);
        done_pulse(4'b0100);
        apb_xfer(0, 12'h12C, 0);
        apb_xfer(0, 12'h004, 0);
        apb_xfer(1, 12'h128, 32'h3);
        apb_xfer(1, 12'h12C, 32'h2, 4'b0100);
        apb_xfer(0, 12'h12C, 0);
        apb_xfer(1, 12'h12C, 32'h2);
        apb_xfer(0, 12'h12C, 0);
        idle(3);

        // decode errors
        apb_xfer(0, 12'h140, 0);
        apb_xfer(0, 12'h0F0, 0);
        apb_xfer(1, 12'h004, 32'hFFFF_FFFF);
        apb_xfer(0, 12'h004, 0);

        // concurrency on channels 0 and 3
        done_pulse(4'b0001);
        apb_xfer(1, 12'h108, 32'h1);
        apb_xfer(1, 12'h138, 32'h1);
        done_pulse(4'b1001);
        apb_xfer(0, 12'h10C, 0);
        apb_xfer(0, 12'h13C, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int op, sel, ch, r;
            logic [NCH-1:0] dn;
            op  = $urandom_range(0, 9);
            sel = $urandom_range(0, 9);
            ch  = $urandom_range(0, NCH);
            r   = (op == 4) ? 0 : (op == 5) ? 1 : (op < 4 || op == 9) ? $urandom_range(0, 3)
                  : (op < 8) ? 2 : 3;
            a   = 12'('h100 + ch * 16 + r * 4 + $urandom_range(0, 3));
            if (sel == 0) a = 12'h000;
            if (sel == 1) a = 12'h004;
            if (sel == 2) a = 12'h0F0;
            dn  = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
            if (op < 4)       apb_xfer(0, a, 0, dn);
            else if (op < 6)  apb_xfer(1, a, $urandom, dn);
            else if (op < 8)  apb_xfer(1, a, 32'($urandom_range(0, 3)), dn);
            else if (op == 8) apb_xfer(1, a, 32'($urandom_range(0, 7)), dn);
            else              done_pulse(NCH'($urandom));
        end
        idle(3);

        // asynchronous reset while channel 1 is busy
        apb_xfer(1, 12'h114, 32'hCAFE_1234);
        apb_xfer(1, 12'h110, 32'h001F_FFFF);
        apb_xfer(1, 12'h118, 32'h3);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        model_clear();
        check("rst_start", 64'(ch_start_o), 64'd0);
        check("rst_irq", 64'(irq_o), 64'd0);
        check("rst_prdata", 64'(apb.prdata), 64'd0);
        check("rst_pslverr", 64'(apb.pslverr), 64'd0);
        check("rst_len1", 64'(hdr_length_o[1]), 64'd0);
        check("rst_reqid1", 64'(hdr_reqid_o[1]), 64'd0);
        check("rst_fmt_all", 64'(hdr_fmt_o), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        apb_xfer(0, 12'h000, 0);
        apb_xfer(0, 12'h11C, 0);
        apb_xfer(0, 12'h110, 0);
        idle(3);

        check("exp_queue_empty", 64'(exp_q.size()), 64'd0);
        check("start_queue_empty", 64'(st_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
